// File: rtl/sdpram_pkg.sv
// Shared types and helpers for the byte-enabled simple dual-port RAM.
package sdpram_pkg;

    localparam int unsigned BYTE_SIZE = 8;

    // Clear sweeps the array once after reset; ready is terminal until reset.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Number of byte lanes in a word of the given width.
    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / BYTE_SIZE;
    endfunction

endpackage

// File: rtl/sdpram_sync_be_if.sv
// Write/read port bundle of the RAM; master is the protocol engine, slave the RAM.
interface sdpram_sync_be_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
);
    import sdpram_pkg::*;

    localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_byte_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_done;

    modport master (
        output wr_en, wr_addr, wr_data, wr_byte_en, rd_en, rd_addr,
        input  rd_data, rd_valid, init_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_byte_en, rd_en, rd_addr,
        output rd_data, rd_valid, init_done
    );

endinterface

// File: rtl/sdpram_sync_array.sv
// Inferred storage: byte-enabled write port, registered read-first read port, no reset.
module sdpram_sync_array
    import sdpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                 i_wr_addr,
    input  logic [DATA_WIDTH-1:0]                 i_wr_data,
    input  logic [be_width(DATA_WIDTH)-1:0]       i_wr_be,
    input  logic                                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0]                 i_rd_addr,
    output logic [DATA_WIDTH-1:0]                 o_rd_data
);

    localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Byte-lane write; disabled lanes keep their contents.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][b*BYTE_SIZE +: BYTE_SIZE] <= i_wr_data[b*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    // Registered read returns pre-write contents on a same-edge collision.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sdpram_sync_be.sv
// Single-clock simple dual-port RAM with byte enables, collision control,
// selectable read latency and a post-reset hardware clear.
module sdpram_sync_be
    import sdpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned OUTPUT_REG     = 1,
    parameter int unsigned RD_BYPASS      = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sdpram_sync_be_if.slave   bus
);

    localparam int unsigned           BE_WIDTH  = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = '1;
    localparam state_t                RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
    logic                  r_init_done;
    logic                  w_init_done_nxt;
    logic                  w_clr_we;

    logic                  w_usr_we;
    logic                  w_usr_re;
    logic                  w_coll;
    logic                  w_arr_we;
    logic [ADDR_WIDTH-1:0] w_arr_waddr;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [BE_WIDTH-1:0]   w_arr_wbe;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    logic                  r_byp_hit;
    logic [BE_WIDTH-1:0]   r_byp_be;
    logic [DATA_WIDTH-1:0] r_byp_data;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  r_vld1;

    // FSM state, clear counter and init flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_STATE;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // Next state: sweep every address once, then stay ready.
    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_init_done_nxt = 1'b0;
        w_clr_we        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt     = ST_READY;
                    w_init_done_nxt = 1'b1;
                end
            end
            ST_READY: begin
                w_init_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = RST_STATE;
            end
        endcase
    end

    // User traffic is accepted only once the array is usable.
    assign w_usr_we = bus.wr_en & r_init_done & (|bus.wr_byte_en);
    assign w_usr_re = bus.rd_en & r_init_done;
    assign w_coll   = (RD_BYPASS != 0) && w_usr_we && w_usr_re && (bus.wr_addr == bus.rd_addr);

    // Write mux: the clear sweep owns the write port until ready.
    assign w_arr_we    = w_clr_we | w_usr_we;
    assign w_arr_waddr = w_clr_we ? r_clr_cnt : bus.wr_addr;
    assign w_arr_wdata = w_clr_we ? '0 : bus.wr_data;
    assign w_arr_wbe   = w_clr_we ? '1 : bus.wr_byte_en;

    sdpram_sync_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_arr_we),
        .i_wr_addr (w_arr_waddr),
        .i_wr_data (w_arr_wdata),
        .i_wr_be   (w_arr_wbe),
        .i_rd_en   (w_usr_re),
        .i_rd_addr (bus.rd_addr),
        .o_rd_data (w_arr_rdata)
    );

    // Capture colliding write lanes alongside each read so later writes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_hit  <= 1'b0;
            r_byp_be   <= '0;
            r_byp_data <= '0;
        end else if (w_usr_re) begin
            r_byp_hit  <= w_coll;
            r_byp_be   <= bus.wr_byte_en;
            r_byp_data <= bus.wr_data;
        end
    end

    // Collision merge: written lanes override the read-first array word.
    always_comb begin
        w_merged = w_arr_rdata;
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (r_byp_hit && r_byp_be[b]) begin
                w_merged[b*BYTE_SIZE +: BYTE_SIZE] = r_byp_data[b*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    // First stage of the read-valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_usr_re;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic                  r_vld2;
            logic [DATA_WIDTH-1:0] r_rd_q;

            // Extra output stage; loads only when a read completes so data holds between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld2 <= 1'b0;
                    r_rd_q <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_rd_q <= w_merged;
                    end
                end
            end

            assign bus.rd_data  = r_rd_q;
            assign bus.rd_valid = r_vld2;
        end else begin : g_noreg
            logic r_has_read;

            // Masks the unreset array register until the first read lands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_has_read <= 1'b0;
                end else if (w_usr_re) begin
                    r_has_read <= 1'b1;
                end
            end

            assign bus.rd_data  = r_has_read ? w_merged : '0;
            assign bus.rd_valid = r_vld1;
        end
    endgenerate

    assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_sdpram_sync_be.sv
// Directed bench: three RAM instances covering clear, byte enables, both
// latencies, both collision modes, streaming, read-after-write and mid-clear reset.
module tb_sdpram_sync_be;

    logic clk = 1'b0;
    logic rst_ab;
    logic rst_c;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sdpram_sync_be_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(32)) if_a ();
    sdpram_sync_be_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(32)) if_b ();
    sdpram_sync_be_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8))  if_c ();

    // A: latency 1, write-first, cleared.
    sdpram_sync_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUTPUT_REG(0), .RD_BYPASS(1), .CLEAR_ON_RESET(1))
        u_a (.clk(clk), .rst_n(rst_ab), .bus(if_a));
    // B: latency 2, read-first, not cleared.
    sdpram_sync_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUTPUT_REG(1), .RD_BYPASS(0), .CLEAR_ON_RESET(0))
        u_b (.clk(clk), .rst_n(rst_ab), .bus(if_b));
    // C: default parameters.
    sdpram_sync_be u_c (.clk(clk), .rst_n(rst_c), .bus(if_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int sel, input logic en, input int addr, input logic [31:0] data, input logic [3:0] be);
        case (sel)
            0: begin if_a.wr_en = en; if_a.wr_addr = 4'(addr); if_a.wr_data = data; if_a.wr_byte_en = be; end
            1: begin if_b.wr_en = en; if_b.wr_addr = 4'(addr); if_b.wr_data = data; if_b.wr_byte_en = be; end
            default: begin if_c.wr_en = en; if_c.wr_addr = 11'(addr); if_c.wr_data = 8'(data); if_c.wr_byte_en = be[0]; end
        endcase
    endtask

    task automatic set_rd(input int sel, input logic en, input int addr);
        case (sel)
            0: begin if_a.rd_en = en; if_a.rd_addr = 4'(addr); end
            1: begin if_b.rd_en = en; if_b.rd_addr = 4'(addr); end
            default: begin if_c.rd_en = en; if_c.rd_addr = 11'(addr); end
        endcase
    endtask

    initial begin
        int   n_a;
        int   n_b;
        int   n_c;
        logic any_v;
        logic any_i;

        rst_ab = 1'b0;
        rst_c  = 1'b0;
        for (int s = 0; s < 3; s++) begin
            set_wr(s, 1'b0, 0, 32'h0, 4'h0);
            set_rd(s, 1'b0, 0);
        end
        repeat (3) tick();

        chk("a_rst_data",  if_a.rd_data,   32'h0);
        chk("a_rst_valid", 32'(if_a.rd_valid),  32'h0);
        chk("a_rst_init",  32'(if_a.init_done), 32'h0);
        chk("b_rst_data",  if_b.rd_data,   32'h0);
        chk("b_rst_valid", 32'(if_b.rd_valid),  32'h0);
        chk("b_rst_init",  32'(if_b.init_done), 32'h0);
        chk("c_rst_data",  32'(if_c.rd_data),   32'h0);
        chk("c_rst_valid", 32'(if_c.rd_valid),  32'h0);
        chk("c_rst_init",  32'(if_c.init_done), 32'h0);

        // Release between edges; count edges until init_done, reading A throughout the clear.
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        n_a = 0; n_b = 0; any_v = 1'b0;
        set_rd(0, 1'b1, 3);
        for (int k = 1; k <= 18; k++) begin
            tick();
            any_v = any_v | if_a.rd_valid;
            if (if_a.init_done && n_a == 0) begin
                n_a = k;
                set_rd(0, 1'b0, 0);
            end
            if (if_b.init_done && n_b == 0) n_b = k;
        end
        chk("a_clear_cycles",      32'(n_a), 32'd16);
        chk("b_noclear_cycles",    32'(n_b), 32'd1);
        chk("a_no_valid_in_clear", 32'(any_v), 32'h0);

        // A: every address reads back zero after the clear.
        for (int i = 0; i < 16; i++) begin
            set_rd(0, 1'b1, i);
            tick();
            chk($sformatf("a_clr_valid_%0d", i), 32'(if_a.rd_valid), 32'h1);
            chk($sformatf("a_clr_data_%0d", i),  if_a.rd_data, 32'h0);
        end
        set_rd(0, 1'b0, 0);
        tick();

        // Byte-enable merge on A (latency 1) and B (latency 2).
        set_wr(0, 1'b1, 5, 32'hAABBCCDD, 4'hF); set_wr(1, 1'b1, 5, 32'hAABBCCDD, 4'hF);
        tick();
        set_wr(0, 1'b1, 5, 32'h11223344, 4'h5); set_wr(1, 1'b1, 5, 32'h11223344, 4'h5);
        tick();
        set_wr(0, 1'b0, 0, 32'h0, 4'h0); set_wr(1, 1'b0, 0, 32'h0, 4'h0);
        set_rd(0, 1'b1, 5); set_rd(1, 1'b1, 5);
        tick();
        set_rd(0, 1'b0, 0); set_rd(1, 1'b0, 0);
        chk("a_be_valid_l1", 32'(if_a.rd_valid), 32'h1);
        chk("a_be_data_l1",  if_a.rd_data, 32'hAA22CC44);
        chk("b_be_valid_l1", 32'(if_b.rd_valid), 32'h0);
        tick();
        chk("a_be_valid_off", 32'(if_a.rd_valid), 32'h0);
        chk("a_be_hold",      if_a.rd_data, 32'hAA22CC44);
        chk("b_be_valid_l2",  32'(if_b.rd_valid), 32'h1);
        chk("b_be_data_l2",   if_b.rd_data, 32'hAA22CC44);
        tick();
        chk("b_be_valid_off", 32'(if_b.rd_valid), 32'h0);
        chk("b_be_hold",      if_b.rd_data, 32'hAA22CC44);

        // Same-address collision: A write-first, B read-first.
        set_wr(0, 1'b1, 7, 32'h0, 4'hF); set_wr(1, 1'b1, 7, 32'h0, 4'hF);
        tick();
        set_wr(0, 1'b1, 7, 32'h5A, 4'h1); set_wr(1, 1'b1, 7, 32'h5A, 4'h1);
        set_rd(0, 1'b1, 7); set_rd(1, 1'b1, 7);
        tick();
        set_wr(0, 1'b0, 0, 32'h0, 4'h0); set_wr(1, 1'b0, 0, 32'h0, 4'h0);
        set_rd(0, 1'b0, 0); set_rd(1, 1'b0, 0);
        chk("a_coll_valid", 32'(if_a.rd_valid), 32'h1);
        chk("a_coll_data",  if_a.rd_data, 32'h5A);
        tick();
        chk("b_coll_valid", 32'(if_b.rd_valid), 32'h1);
        chk("b_coll_data",  if_b.rd_data, 32'h0);
        set_rd(0, 1'b1, 7); set_rd(1, 1'b1, 7);
        tick();
        set_rd(0, 1'b0, 0); set_rd(1, 1'b0, 0);
        chk("a_coll_after", if_a.rd_data, 32'h5A);
        tick();
        chk("b_coll_after", if_b.rd_data, 32'h5A);

        // C: wait for its initial clear to finish.
        for (int k = 0; k < 2100 && !if_c.init_done; k++) tick();
        chk("c_init_wait", 32'(if_c.init_done), 32'h1);

        // Streaming: data = address, then 256 back-to-back reads at latency 2.
        for (int i = 0; i < 256; i++) begin
            set_wr(2, 1'b1, i, 32'(i), 4'h1);
            tick();
        end
        set_wr(2, 1'b0, 0, 32'h0, 4'h0);
        for (int k = 0; k < 258; k++) begin
            set_rd(2, k < 256, k);
            tick();
            chk($sformatf("c_stream_valid_%0d", k), 32'(if_c.rd_valid), (k >= 1 && k <= 256) ? 32'h1 : 32'h0);
            if (k >= 1 && k <= 256) chk($sformatf("c_stream_data_%0d", k), 32'(if_c.rd_data), 32'(k - 1));
        end
        set_rd(2, 1'b0, 0);
        tick();
        chk("c_stream_hold", 32'(if_c.rd_data), 32'hFF);

        // Read-after-write at the top address.
        set_wr(2, 1'b1, 2047, 32'h3C, 4'h1);
        tick();
        set_wr(2, 1'b0, 0, 32'h0, 4'h0);
        set_rd(2, 1'b1, 2047);
        tick();
        set_rd(2, 1'b0, 0);
        tick();
        chk("c_raw_valid", 32'(if_c.rd_valid), 32'h1);
        chk("c_raw_data",  32'(if_c.rd_data),  32'h3C);

        // Reset clears outputs asynchronously; then abort a clear at cycle 1000.
        rst_c = 1'b0;
        #2;
        chk("c_rst2_data",  32'(if_c.rd_data),   32'h0);
        chk("c_rst2_valid", 32'(if_c.rd_valid),  32'h0);
        chk("c_rst2_init",  32'(if_c.init_done), 32'h0);
        rst_c = 1'b1;
        any_i = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            any_i = any_i | if_c.init_done;
        end
        chk("c_init_low_1000", 32'(any_i), 32'h0);
        rst_c = 1'b0;
        tick();
        chk("c_midclr_data",  32'(if_c.rd_data),  32'h0);
        chk("c_midclr_valid", 32'(if_c.rd_valid), 32'h0);
        rst_c = 1'b1;
        n_c = 0;
        for (int k = 1; k <= 2100 && n_c == 0; k++) begin
            tick();
            if (if_c.init_done) n_c = k;
        end
        chk("c_restart_cycles", 32'(n_c), 32'd2048);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
